// File: rtl/morse_tx_sequencer.sv
// morse_tx_sequencer
//   Accepts one ASCII character per handshake, hands it (upper-cased) to an
//   external combinational Morse encoder, and keys the symbols out with
//   standard Morse timing: dot = 1 unit, dash = 3, intra-symbol gap = 1,
//   trailing character gap = 3, space (word gap) = 7 units.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   char_data/valid/ready : character input handshake
//   abort               : drop the current character at the next edge
//   enc_ascii           : registered character to the external encoder
//   enc_code, enc_len   : encoder result (MSB first, 1 = dash; len 0 = unsupported)
//   key_out             : transmitter key (1 = tone)
//   busy                : not idle
//   char_done, char_err : one-cycle completion / rejection pulses
module morse_tx_sequencer #(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       abort,
  output logic [7:0] enc_ascii,
  input  logic [4:0] enc_code,
  input  logic [2:0] enc_len,
  output logic       key_out,
  output logic       busy,
  output logic       char_done,
  output logic       char_err
);

  // Counter must hold the longest interval (7 units) minus one.
  localparam int unsigned CW = $clog2(7 * UNIT_CYCLES);
  localparam logic [CW-1:0] C_1U = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] C_3U = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] C_7U = CW'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, MARK, GAP, CHAR_GAP, WORD_GAP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_ascii;
  logic [4:0]    r_shift;
  logic [2:0]    r_count;
  logic [CW-1:0] r_unit;
  logic          r_key;
  logic          r_done;
  logic          r_err;

  logic [7:0]    w_upper;
  logic [CW-1:0] w_first_mark;
  logic [CW-1:0] w_next_mark;
  logic          w_ready;

  always_comb begin
    w_upper = char_data;
    if (char_data >= 8'h61 && char_data <= 8'h7A) w_upper = char_data - 8'h20;
  end

  // First symbol length comes straight from the encoder; later ones from
  // the already-shifted register.
  assign w_first_mark = enc_code[4] ? C_3U : C_1U;
  assign w_next_mark  = r_shift[4]  ? C_3U : C_1U;

  assign w_ready    = (r_state == IDLE) && !abort;
  assign char_ready = w_ready;
  assign enc_ascii  = r_ascii;
  assign key_out    = r_key;
  assign busy       = (r_state != IDLE);
  assign char_done  = r_done;
  assign char_err   = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ascii <= '0;
      r_shift <= '0;
      r_count <= '0;
      r_unit  <= '0;
      r_key   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state != IDLE && abort) begin
        r_state <= IDLE;
        r_key   <= 1'b0;
        r_unit  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (char_valid && w_ready) begin
              r_ascii <= w_upper;
              r_state <= LOAD;
            end
          end
          LOAD: begin
            r_shift <= enc_code;
            r_count <= enc_len;
            if (r_ascii == 8'h20) begin
              r_state <= WORD_GAP;
              r_unit  <= C_7U;
            end else if (enc_len == 3'd0) begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end else begin
              r_state <= MARK;
              r_key   <= 1'b1;
              r_unit  <= w_first_mark;
            end
          end
          MARK: begin
            if (r_unit == '0) begin
              r_count <= r_count - 3'd1;
              r_shift <= {r_shift[3:0], 1'b0};
              r_key   <= 1'b0;
              // r_count still holds the pre-decrement value here.
              if (r_count > 3'd1) begin
                r_state <= GAP;
                r_unit  <= C_1U;
              end else begin
                r_state <= CHAR_GAP;
                r_unit  <= C_3U;
              end
            end else begin
              r_unit <= r_unit - CW'(1);
            end
          end
          GAP: begin
            if (r_unit == '0) begin
              r_state <= MARK;
              r_key   <= 1'b1;
              r_unit  <= w_next_mark;
            end else begin
              r_unit <= r_unit - CW'(1);
            end
          end
          CHAR_GAP, WORD_GAP: begin
            if (r_unit == '0) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_unit <= r_unit - CW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Scoreboard bench for morse_tx_sequencer (UNIT_CYCLES = 4).
// Stimulus pushes {cycle, signal, value} expectations; the monitor compares
// every expectation due in the current cycle on the falling edge.
module tb_morse_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_data = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       abort = 1'b0;
  logic [7:0] enc_ascii;
  logic [4:0] enc_code;
  logic [2:0] enc_len;
  logic       key_out;
  logic       busy;
  logic       char_done;
  logic       char_err;

  morse_tx_sequencer #(.UNIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .abort(abort), .enc_ascii(enc_ascii),
    .enc_code(enc_code), .enc_len(enc_len), .key_out(key_out), .busy(busy),
    .char_done(char_done), .char_err(char_err)
  );

  always #5 clk = ~clk;

  // Minimal external encoder: E ., T -, A .-; everything else unsupported.
  always_comb begin
    enc_code = 5'b00000;
    enc_len  = 3'd0;
    case (enc_ascii)
      8'h45: begin enc_code = 5'b00000; enc_len = 3'd1; end
      8'h54: begin enc_code = 5'b10000; enc_len = 3'd1; end
      8'h41: begin enc_code = 5'b01000; enc_len = 3'd2; end
      default: ;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_KEY = 0, K_DONE = 1, K_ERR = 2, K_READY = 3, K_BUSY = 4, K_ASCII = 5;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] act;

  function automatic string kname(input int k);
    case (k)
      K_KEY:   return "key_out";
      K_DONE:  return "char_done";
      K_ERR:   return "char_err";
      K_READY: return "char_ready";
      K_BUSY:  return "busy";
      default: return "enc_ascii";
    endcase
  endfunction

  function automatic logic [7:0] actual(input int k);
    case (k)
      K_KEY:   return {7'd0, key_out};
      K_DONE:  return {7'd0, char_done};
      K_ERR:   return {7'd0, char_err};
      K_READY: return {7'd0, char_ready};
      K_BUSY:  return {7'd0, busy};
      default: return enc_ascii;
    endcase
  endfunction

  function automatic void push(input int c, input int k, input logic [7:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    q.push_back(e);
  endfunction

  function automatic void push_range(input int t0, input int a, input int b,
                                     input int k, input logic [7:0] v);
    for (int c = a; c <= b; c++) push(t0 + c, k, v);
  endfunction

  // Monitor: compare everything due now; anything overdue is a miss.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = actual(q[i].kind);
        checks++;
        if (q[i].cyc < cyc || act !== q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                   kname(q[i].kind), q[i].cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  // Called 1 time unit after a rising edge; returns likewise in cycle t0+1.
  task automatic handshake(input logic [7:0] ch, output int t0);
    char_data  = ch;
    char_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic next_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin @(posedge clk); n++; end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Expectations for a dot-dash 'A' pattern starting at handshake t0.
  function automatic void expect_a(input int t0);
    push_range(t0, 2, 5, K_KEY, 8'd1);
    push_range(t0, 6, 9, K_KEY, 8'd0);
    push_range(t0, 10, 21, K_KEY, 8'd1);
    push_range(t0, 22, 33, K_KEY, 8'd0);
    push_range(t0, 2, 33, K_DONE, 8'd0);
    push(t0 + 34, K_DONE, 8'd1);
    push(t0 + 34, K_ERR, 8'd0);
  endfunction

  int t0;

  initial begin
    // Reset state
    next_cycles(3);
    rst = 1'b0;
    push(cyc, K_READY, 8'd1);
    push(cyc, K_BUSY, 8'd0);
    push(cyc, K_KEY, 8'd0);
    push(cyc, K_ASCII, 8'h00);
    push(cyc, K_DONE, 8'd0);
    drain();

    // 'E'
    handshake(8'h45, t0);
    push(t0 + 1, K_BUSY, 8'd1);
    push(t0 + 1, K_KEY, 8'd0);
    push_range(t0, 2, 5, K_KEY, 8'd1);
    push_range(t0, 6, 17, K_KEY, 8'd0);
    push_range(t0, 2, 17, K_DONE, 8'd0);
    push(t0 + 17, K_READY, 8'd0);
    push(t0 + 18, K_DONE, 8'd1);
    push(t0 + 18, K_READY, 8'd1);
    push(t0 + 19, K_DONE, 8'd0);
    drain();

    // 'A'
    handshake(8'h41, t0);
    expect_a(t0);
    drain();

    // 'a' is upper-cased
    handshake(8'h61, t0);
    push(t0 + 1, K_ASCII, 8'h41);
    expect_a(t0);
    drain();

    // '#' unsupported
    handshake(8'h23, t0);
    push_range(t0, 1, 4, K_KEY, 8'd0);
    push(t0 + 1, K_ERR, 8'd0);
    push(t0 + 2, K_ERR, 8'd1);
    push(t0 + 2, K_DONE, 8'd0);
    push(t0 + 2, K_BUSY, 8'd0);
    push(t0 + 3, K_ERR, 8'd0);
    push_range(t0, 3, 6, K_DONE, 8'd0);
    drain();

    // Space -> word gap
    handshake(8'h20, t0);
    push_range(t0, 1, 30, K_KEY, 8'd0);
    push_range(t0, 1, 29, K_BUSY, 8'd1);
    push_range(t0, 1, 29, K_DONE, 8'd0);
    push(t0 + 30, K_BUSY, 8'd0);
    push(t0 + 30, K_DONE, 8'd1);
    push(t0 + 30, K_ERR, 8'd0);
    drain();

    // 'T' aborted mid-dash
    handshake(8'h54, t0);
    push_range(t0, 2, 6, K_KEY, 8'd1);
    push(t0 + 7, K_KEY, 8'd0);
    push(t0 + 7, K_BUSY, 8'd0);
    push(t0 + 8, K_READY, 8'd1);
    push_range(t0, 7, 22, K_DONE, 8'd0);
    push_range(t0, 7, 22, K_ERR, 8'd0);
    push_range(t0, 8, 22, K_KEY, 8'd0);
    next_cycles(5);
    abort = 1'b1;
    next_cycles(1);
    abort = 1'b0;
    drain();

    // 'T' interrupted by reset mid-dash
    handshake(8'h54, t0);
    push_range(t0, 2, 6, K_KEY, 8'd1);
    push(t0 + 7, K_KEY, 8'd0);
    push(t0 + 7, K_BUSY, 8'd0);
    push(t0 + 7, K_ASCII, 8'h00);
    push(t0 + 7, K_READY, 8'd1);
    push_range(t0, 7, 22, K_DONE, 8'd0);
    push_range(t0, 7, 22, K_ERR, 8'd0);
    push_range(t0, 8, 22, K_KEY, 8'd0);
    next_cycles(5);
    rst = 1'b1;
    next_cycles(1);
    rst = 1'b0;
    drain();

    // Back-to-back 'E' then 'T' with char_valid held high
    char_data  = 8'h45;
    char_valid = 1'b1;
    t0 = cyc;
    next_cycles(1);
    char_data = 8'h54;
    push(t0 + 17, K_READY, 8'd0);
    push(t0 + 18, K_READY, 8'd1);
    push(t0 + 18, K_DONE, 8'd1);
    push(t0 + 19, K_ASCII, 8'h54);
    push(t0 + 19, K_BUSY, 8'd1);
    push(t0 + 19, K_KEY, 8'd0);
    push_range(t0, 20, 31, K_KEY, 8'd1);
    push_range(t0, 32, 43, K_KEY, 8'd0);
    push_range(t0, 19, 43, K_DONE, 8'd0);
    push(t0 + 44, K_DONE, 8'd1);
    next_cycles(18);
    char_valid = 1'b0;
    drain();

    // Abort in IDLE blocks acceptance
    abort      = 1'b1;
    char_data  = 8'h45;
    char_valid = 1'b1;
    push(cyc, K_READY, 8'd0);
    push(cyc + 1, K_BUSY, 8'd0);
    push(cyc + 2, K_KEY, 8'd0);
    next_cycles(1);
    char_valid = 1'b0;
    abort      = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
